inv_sqrt_pipe: RTL

INV_SQRT_PIPE -- requirements
Module: inv_sqrt_pipe

---
 rtl/inv_sqrt_pipe.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/inv_sqrt_pipe.sv
// -----------------------------------------------------------------------------
// inv_sqrt_pipe
// Pipelined fast inverse square root for IEEE-754 single precision.
// Stage 0 forms the magic-constant estimate y0 = MAGIC - (x >> 1) and
// xh = 0.5*x. Each Newton-Raphson iteration then takes four registered stages:
// yy = y*y, t = xh*yy, u = 1.5 - t, y' = y*u. Arithmetic uses round-to-nearest-
// even, and denormal operands and results are flushed to +0.
//
// Parameters:
//   ITERATIONS  number of refinement iterations (1..3)
//   TAG_W       width of the sideband tag (1..16)
//   MAGIC       initial-estimate constant
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (takes priority over Stall)
//   DataIn       operand x (single precision)
//   DataInValid  DataIn/TagIn carry a sample this cycle
//   TagIn        sideband tag, passed through unchanged
//   Stall        freezes the whole pipeline, inputs ignored
//   DataOut      approximately 1/sqrt(x)
//   DataValid    DataOut/TagOut hold a result
//   TagOut       tag belonging to DataOut
//
// Optional feature: define INV_SQRT_SPECIAL_EN to classify zero, denormal,
// negative, infinite and NaN operands in stage 0 and override the result.
// -----------------------------------------------------------------------------
module inv_sqrt_pipe #(
    parameter int          ITERATIONS = 1,
    parameter int          TAG_W      = 4,
    parameter logic [31:0] MAGIC      = 32'h5F3759DF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      DataIn,
    input  logic             DataInValid,
    input  logic [TAG_W-1:0] TagIn,
    input  logic             Stall,
    output logic [31:0]      DataOut,
    output logic             DataValid,
    output logic [TAG_W-1:0] TagOut
);

    localparam int          STAGES = 1 + 4 * ITERATIONS;
    localparam int          LAST   = STAGES - 1;
    localparam logic [31:0] ONE_P5 = 32'h3FC00000;

    // Rounding: RNE on a 23-bit fraction plus guard/sticky, then range check.
    function automatic logic [31:0] fp_round(input logic s, input logic signed [9:0] e,
                                             input logic [22:0] m, input logic g,
                                             input logic st);
        logic [23:0]        r;
        logic signed [9:0]  er;
        r  = {1'b0, m} + {23'd0, g & (st | m[0])};
        er = r[23] ? e + 10'sd1 : e;
        if (er <= 10'sd0)   return 32'd0;
        if (er >= 10'sd255) return {s, 8'hFF, 23'd0};
        return {s, er[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       p;
        logic signed [9:0] e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47])
            return fp_round(a[31] ^ b[31], e + 10'sd1, p[46:24], p[23], |p[22:0]);
        return fp_round(a[31] ^ b[31], e, p[45:23], p[22], |p[21:0]);
    endfunction

    // Adder with three extra low bits (guard, round, sticky) on the aligned
    // mantissas; when exponents differ by 2+ at most one normalising shift
    // is needed, so the sticky bit never reaches the kept fraction.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       hi, lo;
        logic [7:0]        d;
        logic [26:0]       mh, ml, sh, m;
        logic [27:0]       sum;
        logic signed [9:0] e;
        if (b[30:23] == 8'd0) return (a[30:23] == 8'd0) ? 32'd0 : a;
        if (a[30:23] == 8'd0) return b;
        if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
        else begin hi = b; lo = a; end
        d  = hi[30:23] - lo[30:23];
        mh = {1'b1, hi[22:0], 3'b000};
        ml = {1'b1, lo[22:0], 3'b000};
        if (d >= 8'd27) begin
            sh = 27'd1;
        end else begin
            sh = ml >> d;
            if ((sh << d) != ml) sh[0] = 1'b1;
        end
        e = $signed({2'b00, hi[30:23]});
        if (hi[31] == lo[31]) begin
            sum = {1'b0, mh} + {1'b0, sh};
            if (sum[27]) begin
                m    = sum[27:1];
                m[0] = sum[1] | sum[0];
                e    = e + 10'sd1;
            end else begin
                m = sum[26:0];
            end
        end else begin
            m = mh - sh;
            if (m == 27'd0) return 32'd0;
            for (int i = 0; i < 26; i++) begin
                if (!m[26]) begin
                    m = m << 1;
                    e = e - 10'sd1;
                end
            end
        end
        return fp_round(hi[31], e, m[25:3], m[2], |m[1:0]);
    endfunction

    logic [31:0]      y_p   [STAGES];
    logic [31:0]      xh_p  [STAGES];
    logic [31:0]      w_p   [STAGES];
    logic             vld_p [STAGES];
    logic [TAG_W-1:0] tag_p [STAGES];
    logic [31:0]      y_n   [STAGES];
    logic [31:0]      xh_n  [STAGES];
    logic [31:0]      w_n   [STAGES];
    logic             vld_n [STAGES];
    logic [TAG_W-1:0] tag_n [STAGES];
`ifdef INV_SQRT_SPECIAL_EN
    logic             sp_p  [STAGES];
    logic [31:0]      spv_p [STAGES];
    logic             sp_n  [STAGES];
    logic [31:0]      spv_n [STAGES];
`endif

    always_comb begin
        // Stage 0: magic-constant estimate and halved operand
        y_n[0]   = MAGIC - (DataIn >> 1);
        xh_n[0]  = (DataIn[30:23] <= 8'd1) ? 32'd0
                 : {DataIn[31], DataIn[30:23] - 8'd1, DataIn[22:0]};
        w_n[0]   = 32'd0;
        vld_n[0] = DataInValid;
        tag_n[0] = TagIn;
`ifdef INV_SQRT_SPECIAL_EN
        sp_n[0]  = 1'b1;
        spv_n[0] = 32'h7FC00000;
        if (DataIn[30:23] == 8'd0)                         spv_n[0] = 32'h7F800000;
        else if (DataIn[30:23] == 8'hFF && DataIn[22:0] != 23'd0) spv_n[0] = 32'h7FC00000;
        else if (DataIn[31])                               spv_n[0] = 32'h7FC00000;
        else if (DataIn[30:23] == 8'hFF)                   spv_n[0] = 32'h00000000;
        else                                               sp_n[0]  = 1'b0;
`endif
        // Iteration stages: yy, t, u, y' in a repeating group of four
        for (int k = 1; k < STAGES; k++) begin
            y_n[k]   = y_p[k-1];
            xh_n[k]  = xh_p[k-1];
            w_n[k]   = w_p[k-1];
            vld_n[k] = vld_p[k-1];
            tag_n[k] = tag_p[k-1];
`ifdef INV_SQRT_SPECIAL_EN
            sp_n[k]  = sp_p[k-1];
            spv_n[k] = spv_p[k-1];
`endif
            case ((k - 1) % 4)
                0:       w_n[k] = fp_mul(y_p[k-1], y_p[k-1]);
                1:       w_n[k] = fp_mul(xh_p[k-1], w_p[k-1]);
                2:       w_n[k] = fp_add(ONE_P5, {~w_p[k-1][31], w_p[k-1][30:0]});
                default: y_n[k] = fp_mul(y_p[k-1], w_p[k-1]);
            endcase
        end
`ifdef INV_SQRT_SPECIAL_EN
        if (sp_p[LAST-1]) y_n[LAST] = spv_p[LAST-1];
`endif
    end

    // Only valid bits and the output-facing registers are reset; in-flight
    // data is discarded by clearing its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
            y_p[LAST]   <= 32'd0;
            tag_p[LAST] <= '0;
        end else if (!Stall) begin
            for (int k = 0; k < STAGES; k++) begin
                y_p[k]   <= y_n[k];
                xh_p[k]  <= xh_n[k];
                w_p[k]   <= w_n[k];
                vld_p[k] <= vld_n[k];
                tag_p[k] <= tag_n[k];
`ifdef INV_SQRT_SPECIAL_EN
                sp_p[k]  <= sp_n[k];
                spv_p[k] <= spv_n[k];
`endif
            end
        end
    end

    assign DataOut   = y_p[LAST];
    assign DataValid = vld_p[LAST];
    assign TagOut    = tag_p[LAST];

endmodule
